lzd_norm_pipe: RTL
==================

Name: lzd_norm_pipe

Overview:
Parametrised, pipelined leading-zero counter and normaliser for the ICDF GRNG datapath; the next generation of the fixed 61-bit LZD. It takes a W-bit unsigned word, counts leading zeros with a log-depth valid/position tree, and left-shifts the word so its MSB is 1. Results carry a sideband tag through a stallable valid/ready pipeline. It sits between the uniform-word generator and the segment-index / mantissa stage of the ICDF lookup.

Parameters:
W, 61, input word width; 2 <= W <= 128.
PIPELINED, 1, 1 = register after every tree level; 0 = whole tree in one cycle.
TAG_W, 4, sideband tag width (channel/sample ID); must be >= 1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input word valid
in_ready  out  1  block can accept a word this cycle
in_data  in  W  word to analyse
in_tag  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_cnt  out  CW  leading-zero count, CW = clog2(W+1)
out_zero  out  1  in_data was all zeros
out_norm  out  W  in_data << out_cnt (MSB = 1 unless out_zero)
out_tag  out  TAG_W  tag of this result

Behaviour:
- Derived: L = clog2(W); P = 2^L. The word is padded at the LSB end with P-W ones, as the existing LZD does, so an all-zero word yields count W.
- Tree level 1: per bit pair, v = hi|lo, p = ~hi&lo. Level k merges node pairs: v = vH|vL; p = {~vH, vH ? pH : pL}. Final p is the count, zero-extended to CW bits.
- out_zero = 1 iff in_data == 0; out_cnt = W in that case; out_norm = 0.
- Normalise stage: barrel left shift by the count, always its own registered stage.
- Latency from accepted input to out_valid: PIPELINED=1 -> L+1 cycles; PIPELINED=0 -> 2 cycles. Throughput 1 word/cycle when out_ready stays high.
- Each stage holds a valid bit. A stage loads when it is empty or when its occupant moves on the same cycle. in_ready = ~v[0] | advance[0]. This is combinational from out_ready through the chain; no skid buffer.
- Transfer rules: input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready. While out_valid=1 and out_ready=0, all out_* hold stable.
- Every stage carries data, tag and zero flag together; ordering is strictly FIFO.
- Reset: all stage valid bits and all data/tag registers clear to 0 asynchronously. Outputs after reset: out_valid=0, out_cnt=0, out_zero=0, out_norm=0, out_tag=0. Release takes effect synchronously on the next clk edge. Reset mid-flight discards all in-flight words, with no partial output.
- Simultaneous accept and emit with the pipeline full is legal and keeps it full.
- in_data/in_tag are ignored when in_valid=0. The tree is never enabled from stale data.

Decomposition:
- Shared package lzd_pkg: clog2 constant function, L/P/CW derivation, pad-with-ones helper.
- One sub-module lzd_merge_node (parameter PW): merges two (v,p) pairs into (v, PW+1-bit p). It is instanced in a generate loop per level; level registers are generated around it when PIPELINED=1.

Test Plan:
1. W=61, PIPELINED=1, in_data=1<<60, tag=3 -> after 7 cycles out_cnt=0, out_zero=0, out_norm=1<<60, out_tag=3.
2. in_data=1 -> out_cnt=60, out_norm=1<<60. in_data=0 -> out_cnt=61, out_zero=1, out_norm=0.
3. Stream 64 random words with out_ready=1, then sweep all 61 single-bit words -> one result per cycle, in order; out_cnt matches a golden count (60-msb_index); tags preserved.
4. Hold out_ready=0 for 10 cycles while driving in_valid=1 -> exactly L+1=7 words accepted, then in_ready=0. Outputs are stable while stalled. On release, words drain in order with no loss or duplication.
5. Assert rst low mid-stream with 4 words in flight -> out_valid=0 and all out_* = 0 immediately (asynchronously). After release, the first new word appears 7 cycles after acceptance.
6. PIPELINED=0, W=16: in_data=16'h00F0 -> out_cnt=8, out_norm=16'hF000, latency 2. in_data=16'h0000 -> out_cnt=16, out_zero=1.

Source files
------------

// File: rtl/lzd_pkg.sv
// lzd_pkg
// Shared derivations for the leading-zero detector / normaliser:
//   lzd_clog2      - ceiling log2 usable in constant expressions
//   lzd_levels     - number of tree levels L for a W-bit word
//   lzd_pad_width  - padded tree width P = 2^L
//   lzd_cnt_width  - count width CW = clog2(W+1)
//   lzd_pad_ones   - number of ones appended at the LSB end (P-W)
package lzd_pkg;

    function automatic int lzd_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int lzd_levels(input int w);
        return lzd_clog2(w);
    endfunction

    function automatic int lzd_pad_width(input int w);
        return 1 << lzd_clog2(w);
    endfunction

    function automatic int lzd_cnt_width(input int w);
        return lzd_clog2(w + 1);
    endfunction

    // Ones below the LSB make an all-zero word count exactly W.
    function automatic int lzd_pad_ones(input int w);
        return lzd_pad_width(w) - w;
    endfunction

endpackage

// File: rtl/lzd_merge_node.sv
// lzd_merge_node
// Merges two (valid, position) pairs of the leading-zero tree.
//   v_hi, p_hi : pair covering the more significant half
//   v_lo, p_lo : pair covering the less significant half
//   v          : any bit set in either half
//   p          : leading-zero count of the merged span (PW+1 bits)
module lzd_merge_node
    import lzd_pkg::*;
#(
    parameter int PW = 1
) (
    input  logic          v_hi,
    input  logic [PW-1:0] p_hi,
    input  logic          v_lo,
    input  logic [PW-1:0] p_lo,
    output logic          v,
    output logic [PW:0]   p
);

    assign v = v_hi | v_lo;
    // If the upper half is empty, the count is half the span plus the
    // lower half's count; the MSB of p supplies the "half the span".
    assign p = {~v_hi, v_hi ? p_hi : p_lo};

endmodule

// File: rtl/lzd_norm_pipe.sv
// lzd_norm_pipe
// Pipelined leading-zero counter and normaliser with a stallable
// valid/ready pipeline and a sideband tag.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   in_valid   : input word valid
//   in_ready   : block can accept a word this cycle
//   in_data    : W-bit word to analyse
//   in_tag     : sideband tag, passed through unchanged
//   out_valid  : result valid
//   out_ready  : downstream accepts result
//   out_cnt    : leading-zero count (W when the word is zero)
//   out_zero   : word was all zeros
//   out_norm   : word shifted left by out_cnt
//   out_tag    : tag of this result
module lzd_norm_pipe
    import lzd_pkg::*;
#(
    parameter  int W         = 61,
    parameter  int PIPELINED = 1,
    parameter  int TAG_W     = 4,
    localparam int CW        = lzd_cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_cnt,
    output logic             out_zero,
    output logic [W-1:0]     out_norm,
    output logic [TAG_W-1:0] out_tag
);

    localparam int L   = lzd_levels(W);
    localparam int P   = lzd_pad_width(W);
    localparam int PAD = lzd_pad_ones(W);
    // Tree stages plus the normalise stage.
    localparam int NS  = (PIPELINED != 0) ? L + 1 : 2;
    localparam logic [CW-1:0] CNT_ALL = CW'(W);

    logic [P-1:0]  padded;
    logic [NS-1:0] vld;
    logic [NS-1:0] vld_in;
    logic [NS-1:0] ld;
    logic [NS-1:0] en;

    if (PAD > 0) begin : g_pad
        assign padded = {in_data, {PAD{1'b1}}};
    end else begin : g_nopad
        assign padded = in_data;
    end

    // A stage can load when it is empty or anything downstream of it
    // frees up this cycle; computed as a running OR so each bit depends
    // only on valid bits and out_ready.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int s = NS - 1; s >= 0; s--) begin
            acc   = acc | ~vld[s];
            ld[s] = acc;
        end
    end

    assign vld_in   = {vld[NS-2:0], in_valid};
    // Registers only capture when a real word arrives.
    assign en       = ld & vld_in;
    assign in_ready = ld[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (ld[s]) begin
                    vld[s] <= vld_in[s];
                end
            end
        end
    end

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int N   = P >> k;
        localparam bit REG = (PIPELINED != 0) || (k == L);
        localparam int S   = (PIPELINED != 0) ? k - 1 : 0;

        logic [N-1:0]     v_d;
        logic [N-1:0]     v_o;
        logic [N*k-1:0]   p_d;
        logic [N*k-1:0]   p_o;
        logic [W-1:0]     data_i;
        logic [W-1:0]     data_o;
        logic [TAG_W-1:0] tag_i;
        logic [TAG_W-1:0] tag_o;
        logic             zero_i;
        logic             zero_o;

        if (k == 1) begin : g_leaf
            assign data_i = in_data;
            assign tag_i  = in_tag;
            assign zero_i = (in_data == '0);
            for (genvar i = 0; i < N; i++) begin : g_pair
                assign v_d[i] = padded[2*i+1] | padded[2*i];
                assign p_d[i] = ~padded[2*i+1] & padded[2*i];
            end
        end else begin : g_merge
            assign data_i = g_lvl[k-1].data_o;
            assign tag_i  = g_lvl[k-1].tag_o;
            assign zero_i = g_lvl[k-1].zero_o;
            for (genvar i = 0; i < N; i++) begin : g_node
                lzd_merge_node #(
                    .PW (k - 1)
                ) u_node (
                    .v_hi (g_lvl[k-1].v_o[2*i+1]),
                    .p_hi (g_lvl[k-1].p_o[(2*i+1)*(k-1) +: (k-1)]),
                    .v_lo (g_lvl[k-1].v_o[2*i]),
                    .p_lo (g_lvl[k-1].p_o[(2*i)*(k-1) +: (k-1)]),
                    .v    (v_d[i]),
                    .p    (p_d[i*k +: k])
                );
            end
        end

        if (REG) begin : g_reg
            logic [N-1:0]     v_q;
            logic [N*k-1:0]   p_q;
            logic [W-1:0]     data_q;
            logic [TAG_W-1:0] tag_q;
            logic             zero_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q    <= '0;
                    p_q    <= '0;
                    data_q <= '0;
                    tag_q  <= '0;
                    zero_q <= 1'b0;
                end else if (en[S]) begin
                    v_q    <= v_d;
                    p_q    <= p_d;
                    data_q <= data_i;
                    tag_q  <= tag_i;
                    zero_q <= zero_i;
                end
            end

            assign v_o    = v_q;
            assign p_o    = p_q;
            assign data_o = data_q;
            assign tag_o  = tag_q;
            assign zero_o = zero_q;
        end else begin : g_comb
            assign v_o    = v_d;
            assign p_o    = p_d;
            assign data_o = data_i;
            assign tag_o  = tag_i;
            assign zero_o = zero_i;
        end
    end

    logic [CW-1:0]    cnt_tree;
    logic [CW-1:0]    cnt_sel;
    logic [CW-1:0]    cnt_q;
    logic [W-1:0]     norm_q;
    logic [TAG_W-1:0] tag_q;
    logic             zero_q;

    always_comb begin
        cnt_tree        = '0;
        cnt_tree[L-1:0] = g_lvl[L].p_o;
    end

    // With padding the root is always valid; it is empty only when W is a
    // power of two and the word is zero, where the tree count is not W.
    assign cnt_sel = g_lvl[L].v_o[0] ? cnt_tree : CNT_ALL;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            norm_q <= '0;
            tag_q  <= '0;
            zero_q <= 1'b0;
        end else if (en[NS-1]) begin
            cnt_q  <= cnt_sel;
            norm_q <= g_lvl[L].data_o << cnt_sel;
            tag_q  <= g_lvl[L].tag_o;
            zero_q <= g_lvl[L].zero_o;
        end
    end

    assign out_valid = vld[NS-1];
    assign out_cnt   = cnt_q;
    assign out_zero  = zero_q;
    assign out_norm  = norm_q;
    assign out_tag   = tag_q;

endmodule
